// File: rtl/conv_encoder_framer.sv
// Rate-1/2 feed-forward convolutional encoder with fixed-length frame control.
// Optional zero-termination tail (K-1 symbols) is built when CONV_ENC_TAIL_EN is defined.
module conv_encoder_framer #(
    parameter int           K         = 3,
    parameter logic [K-1:0] G0        = 3'b111,
    parameter logic [K-1:0] G1        = 3'b101,
    parameter int           FRAME_LEN = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_bit,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [1:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_start,
    output logic       o_last,
    output logic       o_busy
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);

`ifdef CONV_ENC_TAIL_EN
    localparam int TAIL_W = $clog2(K);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1
    } state_t;
`endif

    // Modulo-2 inner product of one generator with the tap vector.
    function automatic logic tap_parity(input logic [K-1:0] gen, input logic [K-1:0] taps);
        return ^(gen & taps);
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [K-2:0]       sr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               first_r;
`ifdef CONV_ENC_TAIL_EN
    logic [TAIL_W-1:0]  tail_cnt_r;
`endif

    logic               slot_free_s;
    logic               accept_s;
    logic               tail_emit_s;
    logic               load_s;
    logic               last_sym_s;
    logic               last_bit_s;
    logic               enc_bit_s;
    logic [K-1:0]       taps_s;
    logic [K-2:0]       sr_nxt_s;
    logic [1:0]         sym_s;

    // Encoder arithmetic: tap vector, coded symbol and shifted register contents.
    always_comb begin
        slot_free_s = !o_valid || i_ready;
        last_bit_s  = (cnt_r == CNT_W'(FRAME_LEN - 1));
        taps_s      = {enc_bit_s, sr_r};
        sr_nxt_s    = taps_s[K-1:1];
        sym_s       = {tap_parity(G1, taps_s), tap_parity(G0, taps_s)};
        load_s      = accept_s || tail_emit_s;
    end

    // Next-state logic and per-cycle accept/emit decisions.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        tail_emit_s = 1'b0;
        last_sym_s  = 1'b0;
        enc_bit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                enc_bit_s = i_bit;
                if (i_valid && slot_free_s) begin
                    accept_s = 1'b1;
                    if (last_bit_s) begin
`ifdef CONV_ENC_TAIL_EN
                        state_nxt_s = ST_TAIL;
`else
                        state_nxt_s = ST_IDLE;
                        last_sym_s  = 1'b1;
`endif
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef CONV_ENC_TAIL_EN
            ST_TAIL: begin
                // Flush zeros through the register to terminate the trellis.
                enc_bit_s = 1'b0;
                if (slot_free_s) begin
                    tail_emit_s = 1'b1;
                    if (tail_cnt_r == TAIL_W'(K - 2)) begin
                        state_nxt_s = ST_IDLE;
                        last_sym_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_TAIL;
                    end
                end else begin
                    state_nxt_s = ST_TAIL;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the registered state and output slot.
    always_comb begin
        o_ready = (state_r == ST_DATA) && slot_free_s;
        o_busy  = (state_r != ST_IDLE) || o_valid;
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Shift register, bit counter and first-symbol flag; a new frame always starts from zero state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sr_r       <= '0;
            cnt_r      <= '0;
            first_r    <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
            tail_cnt_r <= '0;
`endif
        end else if ((state_r == ST_IDLE) && i_start) begin
            sr_r       <= '0;
            cnt_r      <= '0;
            first_r    <= 1'b1;
`ifdef CONV_ENC_TAIL_EN
            tail_cnt_r <= '0;
`endif
        end else if (accept_s) begin
            sr_r    <= sr_nxt_s;
            cnt_r   <= cnt_r + CNT_W'(1);
            first_r <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
        end else if (tail_emit_s) begin
            sr_r       <= sr_nxt_s;
            tail_cnt_r <= tail_cnt_r + TAIL_W'(1);
`endif
        end else begin
            sr_r    <= sr_r;
            cnt_r   <= cnt_r;
            first_r <= first_r;
        end
    end

    // Output symbol slot: a new symbol wins over a concurrent handshake, stalls hold everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= 2'b00;
            o_start <= 1'b0;
            o_last  <= 1'b0;
        end else if (load_s) begin
            o_valid <= 1'b1;
            o_data  <= sym_s;
            o_start <= accept_s && first_r;
            o_last  <= last_sym_s;
        end else if (i_ready) begin
            o_valid <= 1'b0;
            o_data  <= o_data;
            o_start <= 1'b0;
            o_last  <= 1'b0;
        end else begin
            o_valid <= o_valid;
            o_data  <= o_data;
            o_start <= o_start;
            o_last  <= o_last;
        end
    end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Directed bench for conv_encoder_framer (K=3, G0=111, G1=101, FRAME_LEN=4).
// Expected symbols are hand-computed; the tail part applies only when CONV_ENC_TAIL_EN is defined.
module tb_conv_encoder_framer;

    localparam int FL = 4;
`ifdef CONV_ENC_TAIL_EN
    localparam int NSYM = FL + 2;
`else
    localparam int NSYM = FL;
`endif

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic       i_bit;
    logic       i_valid;
    logic       o_ready;
    logic [1:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_start;
    logic       o_last;
    logic       o_busy;

    conv_encoder_framer #(
        .K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(FL)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_bit(i_bit),
        .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_start(o_start), .o_last(o_last), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      in_bits;   // in_bits[i] is the i-th bit sent
        logic [5:0][1:0] syms;      // syms[i] is the i-th expected symbol
    } vec_t;

    typedef struct {
        logic [1:0] d;
        logic       s;
        logic       l;
        int         cyc;
    } obs_t;

    vec_t tv [4];
    obs_t q [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every symbol handshake.
    always @(negedge clk) begin
        if (o_valid && i_ready) q.push_back('{d: o_data, s: o_start, l: o_last, cyc: cyc});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_ready;
        int n = 0;
        @(negedge clk);
        while (!o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("ready_timeout");
    endtask

    task automatic send_bits(input logic [3:0] b, input int nb, input bit mid_start);
        for (int i = 0; i < nb; i++) begin
            i_bit   = b[i];
            i_valid = 1'b1;
            i_start = mid_start && (i == 2);
            wait_ready();
            tick();
        end
        i_valid = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic wait_idle;
        int n = 0;
        @(negedge clk);
        while (o_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("idle_timeout");
        tick();
    endtask

    task automatic compare_frame(input int t, input int base, input string tag);
        for (int i = 0; i < NSYM; i++) begin
            if (base + i < q.size()) begin
                chk($sformatf("%s_data%0d", tag, i), 32'(q[base+i].d), 32'(tv[t].syms[i]));
                chk($sformatf("%s_start%0d", tag, i), 32'(q[base+i].s), 32'(i == 0));
                chk($sformatf("%s_last%0d", tag, i), 32'(q[base+i].l), 32'(i == NSYM - 1));
            end else begin
                fail_now($sformatf("%s_missing%0d", tag, i));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tv[0].in_bits = 4'b1101; tv[0].syms = {2'b11, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
        tv[1].in_bits = 4'b0000; tv[1].syms = {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tv[2].in_bits = 4'b1111; tv[2].syms = {2'b11, 2'b10, 2'b01, 2'b01, 2'b10, 2'b11};
        tv[3].in_bits = 4'b0010; tv[3].syms = {2'b00, 2'b00, 2'b11, 2'b01, 2'b11, 2'b00};

        i_rst = 1'b1; i_start = 1'b0; i_bit = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data",  32'(o_data),  32'd0);
        chk("rst_start", 32'(o_start), 32'd0);
        chk("rst_last",  32'(o_last),  32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_busy",  32'(o_busy),  32'd0);
        i_rst = 1'b0;
        tick();

        // Table-driven frames; row 2 also pulses i_start mid-frame, which must be ignored.
        for (int t = 0; t < 4; t++) begin
            q.delete();
            pulse_start();
            send_bits(tv[t].in_bits, FL, t == 2);
            wait_idle();
            chk($sformatf("frame%0d_count", t), 32'(q.size()), 32'(NSYM));
            compare_frame(t, 0, $sformatf("frame%0d", t));
            chk($sformatf("frame%0d_idle_ready", t), 32'(o_ready), 32'd0);
        end

        // i_valid while idle consumes nothing and emits nothing.
        q.delete();
        i_valid = 1'b1;
        i_bit   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_ivalid_valid", 32'(o_valid), 32'd0);
            chk("idle_ivalid_ready", 32'(o_ready), 32'd0);
        end
        tick();
        i_valid = 1'b0;
        chk("idle_ivalid_count", 32'(q.size()), 32'd0);
        chk("idle_ivalid_busy", 32'(o_busy), 32'd0);

        // Backpressure: stall three cycles while the second symbol is presented.
        q.delete();
        pulse_start();
        fork
            send_bits(tv[0].in_bits, FL, 1'b0);
            begin
                n = 0;
                while (q.size() < 1 && n < 100) begin
                    tick();
                    n++;
                end
                if (n >= 100) fail_now("bp_sync");
                i_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("bp_valid", 32'(o_valid), 32'd1);
                    chk("bp_data",  32'(o_data),  32'h1);
                    chk("bp_ready", 32'(o_ready), 32'd0);
                    tick();
                end
                i_ready = 1'b1;
            end
        join
        wait_idle();
        chk("bp_count", 32'(q.size()), 32'(NSYM));
        compare_frame(0, 0, "bp");

        // Reset mid-frame, then a clean frame must reproduce the reference.
        q.delete();
        pulse_start();
        send_bits(tv[0].in_bits, 2, 1'b0);
        chk("mid_pre_valid", 32'(o_valid), 32'd1);
        i_rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_busy",  32'(o_busy),  32'd0);
        i_rst = 1'b0;
        tick();
        q.delete();
        pulse_start();
        send_bits(tv[0].in_bits, FL, 1'b0);
        wait_idle();
        chk("post_rst_count", 32'(q.size()), 32'(NSYM));
        compare_frame(0, 0, "post_rst");

        // Back-to-back: next start sampled on the edge that takes the last symbol.
        q.delete();
        pulse_start();
        send_bits(tv[0].in_bits, FL, 1'b0);
        n = 0;
        @(negedge clk);
        while (!(o_valid && o_last) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("b2b_last_wait");
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        send_bits(tv[2].in_bits, FL, 1'b0);
        wait_idle();
        chk("b2b_count", 32'(q.size()), 32'(2 * NSYM));
        compare_frame(0, 0, "b2b_a");
        compare_frame(2, NSYM, "b2b_b");
        if (q.size() == 2 * NSYM) begin
            chk("b2b_gap_le1", 32'((q[NSYM].cyc - q[NSYM-1].cyc) <= 2), 32'd1);
        end else begin
            fail_now("b2b_gap");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
